// File: rtl/window_reader_if.sv
// Window coordinate handshake between the window reader and the mult-adder tree.
interface window_reader_if #(
  parameter int COORD_BW = 5
);
  logic                win_valid;
  logic                win_ready;
  logic                win_last;
  logic [COORD_BW-1:0] win_x;
  logic [COORD_BW-1:0] win_y;

  modport master (output win_valid, win_x, win_y, win_last, input win_ready);
  modport slave  (input win_valid, win_x, win_y, win_last, output win_ready);
endinterface

// File: rtl/window_reader.sv
// Window reader: once the window buffer reports full, walks every kernel-sized
// sub-window in raster order at a fixed stride and hands each top-left
// coordinate to the mult-adder tree. Aborts if the loader drops buffer_rdy.
// Optional build macro WINDOW_READER_OVERRUN_CNT_EN adds a saturating abort
// counter (o_overrun_count) with a clear input (i_clr_overrun).
//
// state | meaning
// IDLE  | waiting for a rising edge of buffer_rdy
// SCAN  | presenting windows; abort if buffer_rdy is sampled low
module window_reader #(
  parameter int BUF_W    = 28,
  parameter int BUF_H    = 28,
  parameter int KERNEL_W = 5,
  parameter int KERNEL_H = 5,
  parameter int STRIDE   = 1,
  parameter int COORD_BW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_buffer_rdy,
  window_reader_if.master    win,
  output logic               o_frame_done,
  output logic               o_scan_abort,
  output logic               o_busy
`ifdef WINDOW_READER_OVERRUN_CNT_EN
  ,
  input  logic               i_clr_overrun,
  output logic [7:0]         o_overrun_count
`endif
);

  localparam int NX = (BUF_W - KERNEL_W) / STRIDE + 1;
  localparam int NY = (BUF_H - KERNEL_H) / STRIDE + 1;
  localparam logic [COORD_BW-1:0] XMAX = COORD_BW'((NX - 1) * STRIDE);
  localparam logic [COORD_BW-1:0] YMAX = COORD_BW'((NY - 1) * STRIDE);
  localparam logic [COORD_BW:0]   STEP = (COORD_BW + 1)'(STRIDE);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_rdy_q;
  logic                r_valid, r_last, r_done, r_abort, r_busy;
  logic [COORD_BW-1:0] r_x, r_y;

  logic                w_valid, w_last, w_done, w_abort, w_busy;
  logic [COORD_BW-1:0] w_x, w_y;
  logic [COORD_BW:0]   w_x_inc, w_y_inc;
  logic                w_start, w_accept;

  assign w_start  = i_buffer_rdy & ~r_rdy_q;
  assign w_accept = r_valid & win.win_ready;
  assign w_x_inc  = {1'b0, r_x} + STEP;
  assign w_y_inc  = {1'b0, r_y} + STEP;

  // State, registered outputs and the buffer_rdy history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rdy_q <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_busy  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy_q <= i_buffer_rdy;
      r_valid <= w_valid;
      r_last  <= w_last;
      r_done  <= w_done;
      r_abort <= w_abort;
      r_busy  <= w_busy;
      r_x     <= w_x;
      r_y     <= w_y;
    end
  end

  // Next state and next output values; abort outranks an accept in SCAN.
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = r_valid;
    w_last      = r_last;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_busy      = r_busy;
    w_x         = r_x;
    w_y         = r_y;
    case (r_state)
      IDLE: begin
        w_valid = 1'b0;
        w_busy  = 1'b0;
        w_last  = 1'b0;
        if (w_start) begin
          w_x         = '0;
          w_y         = '0;
          w_valid     = 1'b1;
          w_busy      = 1'b1;
          w_last      = (XMAX == '0) && (YMAX == '0);
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (!i_buffer_rdy) begin
          w_valid     = 1'b0;
          w_busy      = 1'b0;
          w_abort     = 1'b1;
          w_last      = 1'b0;
          w_x         = '0;
          w_y         = '0;
          w_state_nxt = IDLE;
        end else if (w_accept) begin
          if (r_last) begin
            w_valid     = 1'b0;
            w_busy      = 1'b0;
            w_done      = 1'b1;
            w_last      = 1'b0;
            w_x         = '0;
            w_y         = '0;
            w_state_nxt = IDLE;
          end else begin
            if (r_x < XMAX) begin
              w_x = w_x_inc[COORD_BW-1:0];
            end else begin
              w_x = '0;
              w_y = w_y_inc[COORD_BW-1:0];
            end
            w_last = (w_x == XMAX) && (w_y == YMAX);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign win.win_valid = r_valid;
  assign win.win_last  = r_last;
  assign win.win_x     = r_x;
  assign win.win_y     = r_y;
  assign o_frame_done  = r_done;
  assign o_scan_abort  = r_abort;
  assign o_busy        = r_busy;

`ifdef WINDOW_READER_OVERRUN_CNT_EN
  logic [7:0] r_overrun_count;

  // Saturating count of aborted scans; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun_count <= 8'd0;
    end else if (i_clr_overrun) begin
      r_overrun_count <= 8'd0;
    end else if (r_abort && (r_overrun_count != 8'hFF)) begin
      r_overrun_count <= r_overrun_count + 8'd1;
    end
  end

  assign o_overrun_count = r_overrun_count;
`endif

endmodule

// File: tb/tb_window_reader.sv
// Bench for window_reader: two instances (6x6/k3/s1 and 7x7/k3/s2) checked
// every cycle against an index-based model, plus literal expectations.
module tb_window_reader;

  localparam int A_NX = 4, A_S = 1, A_TOT = 16;
  localparam int B_NX = 3, B_S = 2, B_TOT = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy_a = 1'b0, rdy_b = 1'b0;
  logic clr_a = 1'b0;
  logic done_a, abort_a, busy_a, done_b, abort_b, busy_b;
  logic [7:0] cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  window_reader_if #(.COORD_BW(5)) if_a ();
  window_reader_if #(.COORD_BW(5)) if_b ();

  window_reader #(.BUF_W(6), .BUF_H(6), .KERNEL_W(3), .KERNEL_H(3), .STRIDE(1), .COORD_BW(5)) u_a (
    .clk(clk), .rst_n(rst_n), .i_buffer_rdy(rdy_a), .win(if_a.master),
    .o_frame_done(done_a), .o_scan_abort(abort_a), .o_busy(busy_a)
`ifdef WINDOW_READER_OVERRUN_CNT_EN
    , .i_clr_overrun(clr_a), .o_overrun_count(cnt_a)
`endif
  );

  window_reader #(.BUF_W(7), .BUF_H(7), .KERNEL_W(3), .KERNEL_H(3), .STRIDE(2), .COORD_BW(5)) u_b (
    .clk(clk), .rst_n(rst_n), .i_buffer_rdy(rdy_b), .win(if_b.master),
    .o_frame_done(done_b), .o_scan_abort(abort_b), .o_busy(busy_b)
`ifdef WINDOW_READER_OVERRUN_CNT_EN
    , .i_clr_overrun(1'b0), .o_overrun_count(cnt_b)
`endif
  );

`ifndef WINDOW_READER_OVERRUN_CNT_EN
  assign cnt_a = 8'd0;
  assign cnt_b = 8'd0;
`endif

  typedef struct {
    bit active;
    int idx;
    bit done;
    bit abort;
    bit rdy_q;
    int cnt;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.active = 0; m.idx = 0; m.done = 0; m.abort = 0; m.rdy_q = 0; m.cnt = 0;
    return m;
  endfunction

  // One clock of the frame-level behaviour: window index in raster order.
  function automatic mdl_t mdl_step(mdl_t st, bit rdy, bit ready, bit clr, int total);
    mdl_t n = st;
    n.done  = 0;
    n.abort = 0;
    n.rdy_q = rdy;
    if (clr) n.cnt = 0;
    else if (st.abort && st.cnt < 255) n.cnt = st.cnt + 1;
    if (!st.active) begin
      if (rdy && !st.rdy_q) begin
        n.active = 1;
        n.idx    = 0;
      end
    end else if (!rdy) begin
      n.active = 0;
      n.abort  = 1;
      n.idx    = 0;
    end else if (ready) begin
      if (st.idx == total - 1) begin
        n.active = 0;
        n.done   = 1;
        n.idx    = 0;
      end else begin
        n.idx = st.idx + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, rdy_a, if_a.win_ready, clr_a, A_TOT);
      mb = mdl_step(mb, rdy_b, if_b.win_ready, 1'b0, B_TOT);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input int nx, input int s, input int total,
                         input logic v, input logic [4:0] x, input logic [4:0] y, input logic l,
                         input logic d, input logic ab, input logic b, input logic [7:0] c);
    chk({tag, ".valid"}, 32'(v), 32'(m.active));
    chk({tag, ".busy"}, 32'(b), 32'(m.active));
    chk({tag, ".last"}, 32'(l), 32'(m.active && m.idx == total - 1));
    chk({tag, ".frame_done"}, 32'(d), 32'(m.done));
    chk({tag, ".scan_abort"}, 32'(ab), 32'(m.abort));
    if (m.active) begin
      chk({tag, ".win_x"}, 32'(x), 32'((m.idx % nx) * s));
      chk({tag, ".win_y"}, 32'(y), 32'((m.idx / nx) * s));
    end
`ifdef WINDOW_READER_OVERRUN_CNT_EN
    chk({tag, ".overrun_count"}, 32'(c), 32'(m.cnt));
`endif
  endtask

  int acc_a[$], acc_b[$];
  int ndone_a = 0, nabort_a = 0, ndone_b = 0;

  // Per-cycle comparison against the model and accept logging (coord = x*16+y).
  always @(negedge clk) begin
    if (rst_n) begin
      cmp_dut("A", ma, A_NX, A_S, A_TOT, if_a.win_valid, if_a.win_x, if_a.win_y, if_a.win_last,
              done_a, abort_a, busy_a, cnt_a);
      cmp_dut("B", mb, B_NX, B_S, B_TOT, if_b.win_valid, if_b.win_x, if_b.win_y, if_b.win_last,
              done_b, abort_b, busy_b, cnt_b);
      if (if_a.win_valid && if_a.win_ready) acc_a.push_back(int'(if_a.win_x) * 16 + int'(if_a.win_y));
      if (if_b.win_valid && if_b.win_ready) acc_b.push_back(int'(if_b.win_x) * 16 + int'(if_b.win_y));
      if (done_a) ndone_a++;
      if (abort_a) nabort_a++;
      if (done_b) ndone_b++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".A.valid"}, 32'(if_a.win_valid), 0);
    chk({tag, ".A.busy"}, 32'(busy_a), 0);
    chk({tag, ".A.last"}, 32'(if_a.win_last), 0);
    chk({tag, ".A.done"}, 32'(done_a), 0);
    chk({tag, ".A.abort"}, 32'(abort_a), 0);
    chk({tag, ".A.x"}, 32'(if_a.win_x), 0);
    chk({tag, ".A.y"}, 32'(if_a.win_y), 0);
    chk({tag, ".B.valid"}, 32'(if_b.win_valid), 0);
    chk({tag, ".B.busy"}, 32'(busy_b), 0);
  endtask

  initial begin
    if_a.win_ready = 1'b1;
    if_b.win_ready = 1'b1;
    #22;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(3);

    // Full scans on both instances with ready held high.
    acc_a.delete(); acc_b.delete(); ndone_a = 0; ndone_b = 0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    tick(1);
    chk("first_valid_a", 32'(if_a.win_valid), 1);
    tick(24);
    chk("a_accepts", 32'(acc_a.size()), 16);
    if (acc_a.size() == 16) begin
      chk("a_first", 32'(acc_a[0]), 0);
      chk("a_second", 32'(acc_a[1]), 16);
      chk("a_fifth", 32'(acc_a[4]), 1);
      chk("a_last", 32'(acc_a[15]), 3 * 16 + 3);
    end
    chk("a_done_cnt", 32'(ndone_a), 1);
    chk("b_accepts", 32'(acc_b.size()), 9);
    if (acc_b.size() == 9) begin
      chk("b_second", 32'(acc_b[1]), 2 * 16);
      chk("b_fourth", 32'(acc_b[3]), 2);
      chk("b_last", 32'(acc_b[8]), 4 * 16 + 4);
    end
    chk("b_done_cnt", 32'(ndone_b), 1);

    // buffer_rdy stays high: no second scan.
    tick(50);
    chk("a_no_rescan", 32'(acc_a.size()), 16);
    chk("a_no_rescan_done", 32'(ndone_a), 1);
    chk("b_no_rescan", 32'(acc_b.size()), 9);

    // Back-pressure with ready pattern 1,0,0,1.
    rdy_a = 1'b0;
    tick(2);
    acc_a.delete(); ndone_a = 0;
    rdy_a = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if_a.win_ready = (c % 4 == 0) || (c % 4 == 3);
      tick(1);
    end
    if_a.win_ready = 1'b1;
    chk("bp_accepts", 32'(acc_a.size()), 16);
    if (acc_a.size() == 16) begin
      chk("bp_sixth", 32'(acc_a[5]), 17);
      chk("bp_last", 32'(acc_a[15]), 51);
    end
    chk("bp_done_cnt", 32'(ndone_a), 1);

    // Abort after five accepts, then re-arm.
    rdy_a = 1'b0;
    tick(2);
    acc_a.delete(); ndone_a = 0; nabort_a = 0;
    rdy_a = 1'b1;
    for (int c = 0; c < 30 && acc_a.size() < 5; c++) tick(1);
    chk("abort_wait", 32'(acc_a.size() >= 5), 1);
    rdy_a = 1'b0;
    tick(5);
    chk("abort_cnt", 32'(nabort_a), 1);
    chk("abort_no_done", 32'(ndone_a), 0);
    chk("abort_valid", 32'(if_a.win_valid), 0);
    acc_a.delete();
    rdy_a = 1'b1;
    tick(3);
    chk("rearm_first", 32'(acc_a.size() > 0 ? acc_a[0] : -1), 0);
    tick(20);
    chk("rearm_done_cnt", 32'(ndone_a), 1);

    // Asynchronous reset in the middle of a scan.
    rdy_a = 1'b0;
    tick(2);
    rdy_a = 1'b1;
    tick(4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    #10;
    rst_n = 1'b1;
    tick(3);

`ifdef WINDOW_READER_OVERRUN_CNT_EN
    for (int k = 0; k < 300; k++) begin
      rdy_a = 1'b1;
      tick(1);
      rdy_a = 1'b0;
      tick(1);
    end
    tick(2);
    chk("overrun_sat", 32'(cnt_a), 255);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    chk("overrun_clr", 32'(cnt_a), 0);
    tick(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_reader.md
Name: window_reader

Overview:
- Consumer-side counterpart of the video-stream window loader.
- Waits for the window buffer to report full (buffer_rdy), then scans every kernel-sized sub-window of the BUFFER_W x BUFFER_H pixel buffer in raster order at a fixed stride.
- Each sub-window's top-left coordinate goes to the mult-adder tree over a valid/ready handshake.
- Aborts cleanly if the loader starts overwriting the buffer mid-scan.

Parameters:
- BUF_W, 28, buffer width in pixels
- BUF_H, 28, buffer height in pixels
- KERNEL_W, 5, kernel width
- KERNEL_H, 5, kernel height
- STRIDE, 1, step between windows (both axes)
- COORD_BW, 5, width of window coordinate outputs (holds max(BUF_W,BUF_H)-1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- buffer_rdy  in  1  level from loader; 1 = buffer full and stable
- win_ready  in  1  mult-adder tree accepts current window
- win_valid  out  1  win_x/win_y valid
- win_x  out  COORD_BW  window top-left column in buffer
- win_y  out  COORD_BW  window top-left row in buffer
- win_last  out  1  current window is the final one of the frame
- frame_done  out  1  one-cycle pulse after final window accepted
- scan_abort  out  1  one-cycle pulse when a scan is aborted
- busy  out  1  scan in progress

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low on reset.
  - All outputs and state reset to 0; state = IDLE; rdy_q = 0.
- Derived constants:
  - NX = (BUF_W-KERNEL_W)/STRIDE + 1; NY = (BUF_H-KERNEL_H)/STRIDE + 1 (integer division).
  - XMAX = (NX-1)*STRIDE; YMAX = (NY-1)*STRIDE.
  - Coordinates never exceed XMAX/YMAX.
- rdy_q is buffer_rdy registered every cycle.
- Start condition: start = buffer_rdy & ~rdy_q (rising edge only). A level held high after a completed scan does not restart.
- State IDLE:
  - win_valid=0, busy=0.
  - On start: win_x=0, win_y=0, win_valid=1, busy=1; go to SCAN.
  - First valid window appears on the clock edge where buffer_rdy is first sampled high (0 cycles after sampling, 1 cycle after the input rises).
- State SCAN:
  - While win_valid & ~win_ready: win_x, win_y and win_last hold stable.
  - On accept (win_valid & win_ready):
    - If win_x < XMAX: win_x += STRIDE.
    - Otherwise: win_x = 0 and win_y += STRIDE.
  - win_last = (win_x==XMAX && win_y==YMAX), registered so it is aligned with the coordinates.
  - Accept while win_last=1: win_valid=0, frame_done=1 for one cycle, busy=0, go to IDLE.
  - Throughput: one window per cycle when win_ready is held high; NX*NY accepts per frame.
- Abort:
  - In SCAN, buffer_rdy sampled 0 means the loader is overwriting the buffer.
  - Next cycle: win_valid=0, busy=0, scan_abort pulses 1 cycle, coordinates reset to 0, go to IDLE.
  - Abort has priority over a simultaneous accept; frame_done is not raised.
- Re-arm: a new rising edge of buffer_rdy after an abort or done starts a fresh scan.
- start in the same cycle frame_done is produced: ignored, because rdy_q is already 1.
- Reset asserted mid-scan: immediate return to IDLE, all outputs 0, no pulses.
- Arithmetic: coordinate adders are COORD_BW+1 bits wide; comparisons are against constants, so there is no wrap-around.

Optional Feature:
- Macro: WINDOW_READER_OVERRUN_CNT_EN.
- Defined:
  - Adds output overrun_count (8 bits), reset 0.
  - Increments on every scan_abort pulse and saturates at 255.
  - Adds input clr_overrun (1 bit); when high, zeroes the counter the next cycle, with priority over increment.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- Setup: BUF_W=BUF_H=6, KERNEL=3, STRIDE=1, win_ready=1. Raise buffer_rdy.
  - Expect 16 consecutive windows, (0,0),(1,0)…(3,3).
  - win_last only on (3,3); frame_done one cycle later; busy falls.
- Same setup with win_ready toggling 1,0,0,1 repeatedly: coordinates stable while ready=0; exactly 16 accepts; order unchanged.
- STRIDE=2, BUF 7x7, KERNEL 3: windows x,y ∈ {0,2,4}, 9 total; last at (4,4).
- Drop buffer_rdy after 5 accepts: scan_abort pulses once; win_valid=0 next cycle; no frame_done.
  - Re-raise buffer_rdy: scan restarts at (0,0).
- Hold buffer_rdy high after frame_done for 50 cycles: no second scan. Assert reset mid-scan: all outputs 0 immediately.
- With WINDOW_READER_OVERRUN_CNT_EN: force 300 aborts and expect overrun_count=255; pulse clr_overrun and expect 0 the next cycle.
